// File: rtl/game_end_of_game_timer_score_if.sv
// Signal bundle between the game master and the end-of-game timer/score block.
// The master drives start, game_won and score_clear. The timer drives everything else.
interface game_end_of_game_timer_score_if #(
    parameter int SCORE_DIGITS = 2
);
    logic                      end_of_game_timer_start;
    logic                      game_won;
    logic                      score_clear;
    logic                      end_of_game_timer_running;
    logic                      result_valid;
    logic                      last_won;
    logic                      blink;
    logic [4*SCORE_DIGITS-1:0] win_score;
    logic [4*SCORE_DIGITS-1:0] loss_score;

    modport master (
        output end_of_game_timer_start, game_won, score_clear,
        input  end_of_game_timer_running, result_valid, last_won, blink,
               win_score, loss_score
    );

    modport slave (
        input  end_of_game_timer_start, game_won, score_clear,
        output end_of_game_timer_running, result_valid, last_won, blink,
               win_score, loss_score
    );
endinterface

// File: rtl/game_end_of_game_timer_score.sv
// End-of-game pause timer. It tallies each round's result into saturating BCD win/loss scores.
// It also drives the overlay blink while the pause runs.
module game_end_of_game_timer_score #(
    parameter int TIMER_CYCLES = 100000000,
    parameter int BLINK_CYCLES = 12500000,
    parameter int SCORE_DIGITS = 2
) (
    input  logic clk,
    input  logic rst,
    game_end_of_game_timer_score_if.slave bus
);
    localparam int CNT_W   = $clog2(TIMER_CYCLES);
    localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);
    localparam int SCORE_W = 4 * SCORE_DIGITS;
    localparam logic [CNT_W-1:0]   CNT_LOAD   = CNT_W'(TIMER_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_CYCLES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg;
    logic [BLINK_W-1:0]   blink_cnt_reg;
    logic                 won_sticky_reg;
    logic                 blink_reg;
    logic                 result_valid_reg;
    logic                 last_won_reg;
    logic [SCORE_W-1:0]   win_score_reg, loss_score_reg;
    logic [SCORE_W-1:0]   win_inc, loss_inc, win_inc_raw, loss_inc_raw;
    logic [SCORE_DIGITS:0] win_carry, loss_carry;
    logic                 running;
    logic                 start_accept;
    logic                 tally;
    logic                 won_now;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (bus.end_of_game_timer_start) state_next = RUN;
            RUN:  if (cnt_reg == '0)               state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Running must already be high in the start cycle so the master never sees a gap.
    always_comb begin
        running      = (state_reg == RUN) | ((state_reg == IDLE) & bus.end_of_game_timer_start);
        start_accept = (state_reg == IDLE) & bus.end_of_game_timer_start;
        tally        = (state_reg == RUN) & (cnt_reg == '0);
        won_now      = won_sticky_reg | bus.game_won;
    end

    // Ripple BCD increment. When every digit is already 9, the carry-out holds the value.
    assign win_carry[0]  = 1'b1;
    assign loss_carry[0] = 1'b1;
    generate
        for (genvar gi = 0; gi < SCORE_DIGITS; gi++) begin : g_bcd
            logic [3:0] win_digit, loss_digit;
            assign win_digit         = win_score_reg[4*gi +: 4];
            assign loss_digit        = loss_score_reg[4*gi +: 4];
            assign win_carry[gi+1]   = win_carry[gi] & (win_digit == 4'd9);
            assign loss_carry[gi+1]  = loss_carry[gi] & (loss_digit == 4'd9);
            assign win_inc_raw[4*gi +: 4]  = !win_carry[gi]  ? win_digit  :
                                             (win_digit == 4'd9)  ? 4'd0 : win_digit + 4'd1;
            assign loss_inc_raw[4*gi +: 4] = !loss_carry[gi] ? loss_digit :
                                             (loss_digit == 4'd9) ? 4'd0 : loss_digit + 4'd1;
        end
    endgenerate

    assign win_inc  = win_carry[SCORE_DIGITS]  ? win_score_reg  : win_inc_raw;
    assign loss_inc = loss_carry[SCORE_DIGITS] ? loss_score_reg : loss_inc_raw;

    // Pause datapath: counters, sticky win capture, blink and tally
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_reg          <= '0;
            blink_cnt_reg    <= '0;
            won_sticky_reg   <= 1'b0;
            blink_reg        <= 1'b0;
            result_valid_reg <= 1'b0;
            last_won_reg     <= 1'b0;
            win_score_reg    <= '0;
            loss_score_reg   <= '0;
        end else begin
            result_valid_reg <= 1'b0;
            if (start_accept) begin
                cnt_reg        <= CNT_LOAD;
                blink_cnt_reg  <= BLINK_LOAD;
                blink_reg      <= 1'b1;
                won_sticky_reg <= bus.game_won;
            end else if (state_reg == RUN) begin
                won_sticky_reg <= won_now;
                if (tally) begin
                    result_valid_reg <= 1'b1;
                    last_won_reg     <= won_now;
                    blink_reg        <= 1'b0;
                end else begin
                    cnt_reg <= cnt_reg - 1'b1;
                    if (blink_cnt_reg == '0) begin
                        blink_reg     <= ~blink_reg;
                        blink_cnt_reg <= BLINK_LOAD;
                    end else begin
                        blink_cnt_reg <= blink_cnt_reg - 1'b1;
                    end
                end
            end

            // A clear on the tally edge wins over the increment.
            if (bus.score_clear) begin
                win_score_reg  <= '0;
                loss_score_reg <= '0;
            end else if (tally) begin
                if (won_now) win_score_reg  <= win_inc;
                else         loss_score_reg <= loss_inc;
            end
        end
    end

    assign bus.end_of_game_timer_running = running;
    assign bus.result_valid              = result_valid_reg;
    assign bus.last_won                  = last_won_reg;
    assign bus.blink                     = blink_reg;
    assign bus.win_score                 = win_score_reg;
    assign bus.loss_score                = loss_score_reg;
endmodule

// File: tb/tb_game_end_of_game_timer_score.sv
// Testbench for the end-of-game timer/score block (TIMER_CYCLES=8, BLINK_CYCLES=2).
// Rounds come from a vector table, and a scoreboard checks every tally.
module tb_game_end_of_game_timer_score;
    localparam int TC = 8;
    localparam int BC = 2;
    localparam int SD = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    game_end_of_game_timer_score_if #(.SCORE_DIGITS(SD)) bus ();

    game_end_of_game_timer_score #(
        .TIMER_CYCLES(TC), .BLINK_CYCLES(BC), .SCORE_DIGITS(SD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        string name;
        int    won_cycle;     // cycle game_won rises and stays high; -1 = never
        bit    clear;         // score_clear on the tally edge
        int    restart_cycle; // extra start pulse during RUN; -1 = none
        bit    exp_won;
    } round_vec_t;

    typedef struct packed {
        logic       won;
        logic [7:0] win;
        logic [7:0] loss;
    } exp_t;

    round_vec_t vecs[7];
    exp_t       sb_q[$];
    int         model_win  = 0;
    int         model_loss = 0;
    int         pass_cnt   = 0;
    int         total_cnt  = 0;

    task automatic check_val(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [7:0] to_bcd(input int n);
        logic [3:0] tens, ones;
        tens = 4'(n / 10);
        ones = 4'(n % 10);
        return {tens, ones};
    endfunction

    function automatic bit exp_blink(input int c);
        if (c >= 1 && c <= TC) return (((c - 1) / BC) % 2) == 0;
        return 1'b0;
    endfunction

    // Model update for one tally. The expected result is queued for the monitor.
    task automatic push_expect(input bit won, input bit clear);
        exp_t e;
        if (clear) begin
            model_win  = 0;
            model_loss = 0;
        end else if (won) begin
            if (model_win < 99) model_win++;
        end else begin
            if (model_loss < 99) model_loss++;
        end
        e.won  = won;
        e.win  = to_bcd(model_win);
        e.loss = to_bcd(model_loss);
        sb_q.push_back(e);
    endtask

    // Runs one 11-cycle round; cycle c is the clock period that contains negedge number c.
    task automatic run_round(input round_vec_t v, input bit wave);
        for (int c = 0; c <= TC + 2; c++) begin
            @(negedge clk);
            bus.end_of_game_timer_start = (c == 0) || (c == v.restart_cycle);
            bus.game_won    = (v.won_cycle >= 0) && (c >= v.won_cycle);
            bus.score_clear = v.clear && (c == TC);
            if (c == TC) push_expect(v.exp_won, v.clear);
            #1;
            if (wave) begin
                check_val({v.name, "_running"}, int'(bus.end_of_game_timer_running), int'(c <= TC));
                check_val({v.name, "_blink"}, int'(bus.blink), int'(exp_blink(c)));
                check_val({v.name, "_valid"}, int'(bus.result_valid), int'(c == TC + 1));
            end
        end
    endtask

    // Scoreboard monitor: every result_valid pulse consumes one expected tally.
    always @(negedge clk) begin
        #2;
        if (bus.result_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_val("sb_unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_val("sb_last_won", int'(bus.last_won), int'(e.won));
                check_val("sb_win_score", int'(bus.win_score), int'(e.win));
                check_val("sb_loss_score", int'(bus.loss_score), int'(e.loss));
                $display("tally: last_won=%0b win=%02h loss=%02h", bus.last_won, bus.win_score, bus.loss_score);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.end_of_game_timer_start = 1'b0;
        bus.game_won    = 1'b0;
        bus.score_clear = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_win  = 0;
        model_loss = 0;
    endtask

    initial begin
        round_vec_t win_round;
        vecs[0] = '{name:"loss_basic",   won_cycle:-1, clear:1'b0, restart_cycle:-1, exp_won:1'b0};
        vecs[1] = '{name:"late_win_c5",  won_cycle: 5, clear:1'b0, restart_cycle:-1, exp_won:1'b1};
        vecs[2] = '{name:"too_late_c9",  won_cycle: 9, clear:1'b0, restart_cycle:-1, exp_won:1'b0};
        vecs[3] = '{name:"win_at_start", won_cycle: 0, clear:1'b0, restart_cycle:-1, exp_won:1'b1};
        vecs[4] = '{name:"win_last_run", won_cycle: 8, clear:1'b0, restart_cycle:-1, exp_won:1'b1};
        vecs[5] = '{name:"clear_tally",  won_cycle: 3, clear:1'b1, restart_cycle:-1, exp_won:1'b1};
        vecs[6] = '{name:"restart_c4",   won_cycle:-1, clear:1'b0, restart_cycle: 4, exp_won:1'b0};
        win_round = '{name:"preload", won_cycle: 3, clear:1'b0, restart_cycle:-1, exp_won:1'b1};

        bus.end_of_game_timer_start = 1'b0;
        bus.game_won    = 1'b0;
        bus.score_clear = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("rst_running", int'(bus.end_of_game_timer_running), 0);
        check_val("rst_valid", int'(bus.result_valid), 0);
        check_val("rst_last_won", int'(bus.last_won), 0);
        check_val("rst_blink", int'(bus.blink), 0);
        check_val("rst_win", int'(bus.win_score), 0);
        check_val("rst_loss", int'(bus.loss_score), 0);

        foreach (vecs[i]) begin
            run_round(vecs[i], 1'b1);
            $display("round %s done", vecs[i].name);
        end

        // Reset in cycle 4 of a pause aborts it without a tally.
        @(negedge clk);
        bus.end_of_game_timer_start = 1'b1;
        bus.game_won = 1'b1;
        #1 check_val("abort_running_c0", int'(bus.end_of_game_timer_running), 1);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            bus.end_of_game_timer_start = 1'b0;
            rst = (c == 4) ? 1'b0 : 1'b1;
            #1;
            if (c == 4) begin
                model_win  = 0;
                model_loss = 0;
            end
            if (c >= 5) begin
                check_val("abort_running", int'(bus.end_of_game_timer_running), 0);
                check_val("abort_blink", int'(bus.blink), 0);
                check_val("abort_valid", int'(bus.result_valid), 0);
                check_val("abort_win", int'(bus.win_score), 0);
                check_val("abort_loss", int'(bus.loss_score), 0);
            end
        end
        bus.game_won = 1'b0;
        $display("abort sequence done");
        run_round(vecs[0], 1'b1);
        $display("round after abort done");

        // Score carry and saturation: 0x09 -> 0x10 and 0x99 stays 0x99
        do_reset();
        for (int n = 1; n <= 100; n++) begin
            run_round(win_round, 1'b0);
            if (n == 10 || n == 100) begin
                @(negedge clk);
                #1 check_val("preload_win", int'(bus.win_score), int'(to_bcd(n == 10 ? 10 : 99)));
            end
        end
        $display("preload sequence done");

        repeat (3) @(negedge clk);
        #3 check_val("sb_leftover", sb_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
